xiyiji_panel: RTL and testbench

XIYIJI_PANEL -- requirements
Module: xiyiji_panel

---
 rtl/xiyiji_pkg.sv | 25 ++
 rtl/xiyiji_key_debounce.sv | 51 +++++
 rtl/xiyiji_panel.sv | 155 +++++++++++++++
 tb/tb_xiyiji_panel.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xiyiji_pkg.sv
// Shared encodings and parameter defaults for the xiyiji front-panel controller.
package xiyiji_pkg;

    localparam int DEB_CYCLES_DEF  = 20;
    localparam int LONG_CYCLES_DEF = 200;

    typedef enum logic [1:0] {
        M0 = 2'd0,
        M1 = 2'd1,
        M2 = 2'd2,
        M3 = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } panel_state_t;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(2'(m + 2'd1));
    endfunction

endpackage

// File: rtl/xiyiji_key_debounce.sv
// Key conditioner: 2-flop synchroniser, stability counter and press pulse on the
// debounced release-to-pressed (1->0) edge. Debounced level resets to released.
module key_debounce
    import xiyiji_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_level <= r_sync2;
                r_press <= ~r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/xiyiji_panel.sv
// Washer front panel: debounced keys drive a mode/start/emergency FSM.
// Optional long-press abort of a running program is enabled by LONG_PRESS_EN.
//
//   state | meaning
//   IDLE  | choose program with select; start arms if mode != M0
//   ARMED | start_req high, waiting for run_ack
//   RUN   | program running, waiting for done
//   HALT  | emergency latched; start with emergency released returns to IDLE
module xiyiji_panel
    import xiyiji_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_select_n,
    input  logic       key_start_n,
    input  logic       key_emergency_n,
    input  logic       run_ack,
    input  logic       done,
    output logic [1:0] mode,
    output logic       start_req,
    output logic       emergency,
    output logic       abort,
    output logic [1:0] panel_state
);

    logic w_unused_sel_level;
    logic w_sel_press;
    logic w_start_level;
    logic w_start_press;
    logic w_emg_level;
    logic w_emg_press;
    logic w_long_fire;

    panel_state_t r_state;
    mode_t        r_mode;
    logic         r_start_req;
    logic         r_emergency;
    logic         r_abort;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_select (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_select_n),
        .o_level (w_unused_sel_level),
        .o_press (w_sel_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_start_n),
        .o_level (w_start_level),
        .o_press (w_start_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_emergency (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_emergency_n),
        .o_level (w_emg_level),
        .o_press (w_emg_press)
    );

`ifdef LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic [LW-1:0] r_long_cnt;
    logic          w_in_active;

    assign w_in_active = (r_state == ARMED) || (r_state == RUN);
    assign w_long_fire = !w_start_level && w_in_active && (r_long_cnt == LW'(LONG_CYCLES - 1));

    // Saturates at LONG_CYCLES and only clears on release, so one hold fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_long_cnt <= '0;
        end else if (w_start_level) begin
            r_long_cnt <= '0;
        end else if (w_in_active && (r_long_cnt != LW'(LONG_CYCLES))) begin
            r_long_cnt <= r_long_cnt + 1'b1;
        end
    end
`else
    logic w_unused_start_level;

    assign w_unused_start_level = w_start_level;
    assign w_long_fire          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= M0;
            r_start_req <= 1'b0;
            r_emergency <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            if (w_emg_press) begin
                r_state     <= HALT;
                r_emergency <= 1'b1;
                r_start_req <= 1'b0;
            end else if (w_long_fire) begin
                r_state     <= IDLE;
                r_mode      <= M0;
                r_start_req <= 1'b0;
                r_abort     <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        // A start press always masks a simultaneous select press.
                        if (w_start_press) begin
                            if (r_mode != M0) begin
                                r_state     <= ARMED;
                                r_start_req <= 1'b1;
                            end
                        end else if (w_sel_press) begin
                            r_mode <= next_mode(r_mode);
                        end
                    end
                    ARMED: begin
                        if (run_ack) begin
                            r_state     <= RUN;
                            r_start_req <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (done) begin
                            r_state <= IDLE;
                            r_mode  <= M0;
                        end
                    end
                    HALT: begin
                        if (w_start_press && w_emg_level) begin
                            r_state     <= IDLE;
                            r_mode      <= M0;
                            r_emergency <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign mode        = r_mode;
    assign start_req   = r_start_req;
    assign emergency   = r_emergency;
    assign abort       = r_abort;
    assign panel_state = r_state;

endmodule

// File: tb/tb_xiyiji_panel.sv
// Directed and randomized bench for xiyiji_panel against an event-level panel model.
module tb_xiyiji_panel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_select_n = 1'b1;
    logic       key_start_n = 1'b1;
    logic       key_emergency_n = 1'b1;
    logic       run_ack = 1'b0;
    logic       done = 1'b0;
    logic [1:0] mode;
    logic       start_req;
    logic       emergency;
    logic       abort;
    logic [1:0] panel_state;

    int checks = 0;
    int errors = 0;
    int abort_seen = 0;

    // Reference model: program, FSM position and flags at key-event granularity.
    int m_mode = 0;
    int m_state = 0;
    int m_start_req = 0;
    int m_emerg = 0;
    int m_emg_held = 0;
    int m_aborts = 0;

    localparam int ST_IDLE = 0, ST_ARMED = 1, ST_RUN = 2, ST_HALT = 3;

    xiyiji_panel #(.DEB_CYCLES(4), .LONG_CYCLES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_select_n    (key_select_n),
        .key_start_n     (key_start_n),
        .key_emergency_n (key_emergency_n),
        .run_ack         (run_ack),
        .done            (done),
        .mode            (mode),
        .start_req       (start_req),
        .emergency       (emergency),
        .abort           (abort),
        .panel_state     (panel_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (abort === 1'b1) abort_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mode"}, 32'(mode), 32'(m_mode));
        check({tag, ".state"}, 32'(panel_state), 32'(m_state));
        check({tag, ".start_req"}, 32'(start_req), 32'(m_start_req));
        check({tag, ".emergency"}, 32'(emergency), 32'(m_emerg));
        check({tag, ".aborts"}, 32'(abort_seen), 32'(m_aborts));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_select_n = 1'b1;
        key_start_n = 1'b1;
        key_emergency_n = 1'b1;
        run_ack = 1'b0;
        done = 1'b0;
        cyc(3);
        rst = 1'b0;
        m_mode = 0; m_state = ST_IDLE; m_start_req = 0; m_emerg = 0; m_emg_held = 0;
        cyc(2);
    endtask

    task automatic model_press(input bit sel, input bit st);
        if (m_state == ST_IDLE) begin
            if (st) begin
                if (m_mode != 0) begin
                    m_state = ST_ARMED;
                    m_start_req = 1;
                end
            end else if (sel) begin
                m_mode = (m_mode + 1) % 4;
            end
        end else if (m_state == ST_HALT && st && !m_emg_held) begin
            m_state = ST_IDLE;
            m_mode = 0;
            m_emerg = 0;
        end
    endtask

    task automatic tap(input bit sel, input bit st);
        key_select_n = ~sel;
        key_start_n = ~st;
        cyc(10);
        key_select_n = 1'b1;
        key_start_n = 1'b1;
        cyc(10);
        model_press(sel, st);
    endtask

    task automatic emg_press();
        key_emergency_n = 1'b0;
        cyc(10);
        m_state = ST_HALT; m_emerg = 1; m_start_req = 0; m_emg_held = 1;
    endtask

    task automatic emg_release();
        key_emergency_n = 1'b1;
        cyc(10);
        m_emg_held = 0;
    endtask

    task automatic pulse_ack();
        run_ack = 1'b1;
        cyc(1);
        run_ack = 1'b0;
        cyc(2);
        if (m_state == ST_ARMED) begin
            m_state = ST_RUN;
            m_start_req = 0;
        end
    endtask

    task automatic pulse_done();
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(2);
        if (m_state == ST_RUN) begin
            m_state = ST_IDLE;
            m_mode = 0;
        end
    endtask

    initial begin
        // Reset values while rst is held
        cyc(3);
        check("reset.mode", 32'(mode), 0);
        check("reset.start_req", 32'(start_req), 0);
        check("reset.emergency", 32'(emergency), 0);
        check("reset.abort", 32'(abort), 0);
        check("reset.state", 32'(panel_state), ST_IDLE);
        do_reset();

        // Bouncing select yields a single step
        key_select_n = 1'b0; cyc(2); key_select_n = 1'b1; cyc(2);
        key_select_n = 1'b0; cyc(2); key_select_n = 1'b1; cyc(2);
        key_select_n = 1'b0; cyc(2); key_select_n = 1'b1; cyc(1);
        key_select_n = 1'b0; cyc(10); key_select_n = 1'b1; cyc(10);
        m_mode = 1;
        check_all("bounce");

        // Five selects from M0 wrap through M3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tap(1'b1, 1'b0);
            check("select_seq", 32'(mode), 32'((i + 1) % 4));
        end
        tap(1'b1, 1'b0);
        check_all("mode_m2");

        // Start, hold request, exact run_ack handoff, then done
        tap(1'b0, 1'b1);
        check_all("armed");
        cyc(5);
        check_all("armed_hold");
        run_ack = 1'b1;
        check("ack_pre.state", 32'(panel_state), ST_ARMED);
        cyc(1);
        run_ack = 1'b0;
        check("ack_edge.state", 32'(panel_state), ST_RUN);
        check("ack_edge.start_req", 32'(start_req), 0);
        m_state = ST_RUN; m_start_req = 0;
        pulse_done();
        check_all("done");

        // Start with M0 ignored; emergency+select in RUN
        tap(1'b0, 1'b1);
        check_all("start_m0");
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b0);
        tap(1'b0, 1'b1);
        pulse_ack();
        check_all("run_m3");
        key_select_n = 1'b0;
        emg_press();
        key_select_n = 1'b1;
        cyc(10);
        check_all("emg_in_run");

        // HALT exit requires emergency released
        tap(1'b0, 1'b1);
        check_all("halt_held");
        emg_release();
        check_all("halt_released");
        tap(1'b0, 1'b1);
        check_all("halt_exit");

        // Simultaneous select and start: start wins
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b1);
        check_all("sel_start");
        pulse_ack();
        check_all("run_again");

        // Long start hold in RUN
        key_start_n = 1'b0;
        cyc(30);
        key_start_n = 1'b1;
        cyc(10);
`ifdef LONG_PRESS_EN
        m_state = ST_IDLE; m_mode = 0; m_start_req = 0; m_aborts++;
`endif
        check_all("long_hold");

        // Reset while in HALT
        do_reset();
        tap(1'b1, 1'b0);
        emg_press();
        check_all("pre_rst_halt");
        key_emergency_n = 1'b1;
        rst = 1'b1;
        cyc(1);
        m_mode = 0; m_state = ST_IDLE; m_start_req = 0; m_emerg = 0; m_emg_held = 0;
        check_all("rst_in_halt");
        cyc(2);
        rst = 1'b0;
        cyc(12);
        check_all("post_rst_halt");

        // Randomized key and handshake traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: tap(1'b1, 1'b0);
                1: tap(1'b0, 1'b1);
                2: if (m_emg_held != 0) emg_release(); else emg_press();
                3: pulse_ack();
                4: pulse_done();
                default: tap(1'b1, 1'b1);
            endcase
            check_all("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
